comparator_4bit: RTL and testbench



---
 rtl/comparator_4bit.sv | 103 ++++++++++
 tb/tb_comparator_4bit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/comparator_4bit.sv
// Registered WIDTH-bit magnitude comparator slice with cascade inputs; one-cycle latency.
// Define COMPARATOR_SIGNED_EN to treat a/b as two's-complement (use on the MSB slice of a chain only).
module comparator_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic             lt_in,
    output logic             g,
    output logic             e,
    output logic             s,
    output logic             out_valid
);

`ifdef COMPARATOR_SIGNED_EN
    // Inverting both sign bits maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = WIDTH'(1) << (WIDTH - 1);
`else
    localparam logic [WIDTH-1:0] SIGN_FLIP = '0;
`endif

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_eq_above;
    logic [WIDTH-1:0] w_gt_bit;
    logic [WIDTH-1:0] w_lt_bit;
    logic             w_gt;
    logic             w_lt;
    logic             w_all_eq;
    logic             w_g;
    logic             w_e;
    logic             w_s;

    logic r_g;
    logic r_e;
    logic r_s;
    logic r_valid;

    assign w_a = a ^ SIGN_FLIP;
    assign w_b = b ^ SIGN_FLIP;

    // w_eq_above[i] is high when every bit at position >= i matches.
    assign w_eq_above[WIDTH] = 1'b1;

    genvar gi;
    generate
        for (gi = WIDTH - 1; gi >= 0; gi--) begin : g_bit
            assign w_eq_above[gi] = w_eq_above[gi+1] & ~(w_a[gi] ^ w_b[gi]);
            assign w_gt_bit[gi]   = w_eq_above[gi+1] &  w_a[gi] & ~w_b[gi];
            assign w_lt_bit[gi]   = w_eq_above[gi+1] & ~w_a[gi] &  w_b[gi];
        end
    endgenerate

    assign w_gt     = |w_gt_bit;
    assign w_lt     = |w_lt_bit;
    assign w_all_eq = w_eq_above[0];

    always_comb begin
        w_g = 1'b0;
        w_e = 1'b0;
        w_s = 1'b0;
        if (!w_all_eq) begin
            w_g = w_gt;
            w_s = w_lt;
        end else if (eq_in) begin
            w_e = 1'b1;
        end else if (gt_in) begin
            w_g = 1'b1;
        end else if (lt_in) begin
            w_s = 1'b1;
        end else begin
            w_e = 1'b1;
        end
    end

    // Results hold while in_valid is low; only out_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_s     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_g <= w_g;
                r_e <= w_e;
                r_s <= w_s;
            end
        end
    end

    assign g         = r_g;
    assign e         = r_e;
    assign s         = r_s;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_comparator_4bit.sv
// Directed self-checking bench for comparator_4bit; observed vector is {out_valid,g,e,s}.
// Build with COMPARATOR_SIGNED_EN defined to check the signed variant.
module tb_comparator_4bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       gt_in;
    logic       eq_in;
    logic       lt_in;
    logic       g;
    logic       e;
    logic       s;
    logic       out_valid;

    int n_total  = 0;
    int n_passed = 0;

    comparator_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .gt_in     (gt_in),
        .eq_in     (eq_in),
        .lt_in     (lt_in),
        .g         (g),
        .e         (e),
        .s         (s),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [3:0] V_G = 4'b1100;
    localparam logic [3:0] V_E = 4'b1010;
    localparam logic [3:0] V_S = 4'b1001;
    localparam logic [3:0] ZERO = 4'b0000;

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {out_valid, g, e, s};
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        $display("%s: {v,g,e,s} observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                         input logic igt, input logic ieq, input logic ilt);
        in_valid = v;
        a        = ia;
        b        = ib;
        gt_in    = igt;
        eq_in    = ieq;
        lt_in    = ilt;
    endtask

    // Apply one sample, wait for the capturing edge, then check just after it.
    task automatic step(input string tag, input logic v, input logic [3:0] ia, input logic [3:0] ib,
                        input logic igt, input logic ieq, input logic ilt, input logic [3:0] exp);
        drive(v, ia, ib, igt, ieq, ilt);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    function automatic logic [3:0] stream_exp(input logic [3:0] ia, input logic [3:0] ib);
`ifdef COMPARATOR_SIGNED_EN
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        sa = ia;
        sb = ib;
        if (sa > sb) return V_G;
        if (sa < sb) return V_S;
        return V_E;
`else
        if (ia > ib) return V_G;
        if (ia < ib) return V_S;
        return V_E;
`endif
    endfunction

    initial begin
        logic [3:0] sb;
        logic [3:0] last;
        logic [3:0] obs;

        // 1. Reset with in_valid toggling
        rst = 1'b1;
        drive(1'b0, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            @(posedge clk);
        end
        #1;
        check("reset_hold", ZERO);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("after_release", ZERO);

        // 2. Cascade idle
        step("idle_1_3",   1'b1, 4'd1,  4'd3,  1'b0, 1'b1, 1'b0, V_S);
        step("idle_2_2",   1'b1, 4'd2,  4'd2,  1'b0, 1'b1, 1'b0, V_E);
        step("idle_3_1",   1'b1, 4'd3,  4'd1,  1'b0, 1'b1, 1'b0, V_G);
`ifdef COMPARATOR_SIGNED_EN
        step("idle_15_14", 1'b1, 4'd15, 4'd14, 1'b0, 1'b1, 1'b0, V_G);
        step("idle_14_15", 1'b1, 4'd14, 4'd15, 1'b0, 1'b1, 1'b0, V_S);
        step("idle_0_15",  1'b1, 4'd0,  4'd15, 1'b0, 1'b1, 1'b0, V_G);
`else
        step("idle_15_14", 1'b1, 4'd15, 4'd14, 1'b0, 1'b1, 1'b0, V_G);
        step("idle_14_15", 1'b1, 4'd14, 4'd15, 1'b0, 1'b1, 1'b0, V_S);
        step("idle_0_15",  1'b1, 4'd0,  4'd15, 1'b0, 1'b1, 1'b0, V_S);
`endif
        step("idle_0_0",   1'b1, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, V_E);
        step("idle_15_15", 1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0, V_E);

        // 3. Cascade resolution on equal operands
        step("casc_gt",    1'b1, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, V_G);
        step("casc_lt",    1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1, V_S);
        step("casc_none",  1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, V_E);
        step("casc_eqpri", 1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, V_E);
        step("casc_gtpri", 1'b1, 4'd5, 4'd5, 1'b1, 1'b0, 1'b1, V_G);
        step("casc_ignor", 1'b1, 4'd6, 4'd5, 1'b0, 1'b0, 1'b1, V_G);
        step("casc_ignr2", 1'b1, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0, V_S);

        // 4. Back-to-back stream, one sample per clock
        for (int k = 0; k < 16; k++) begin
            sb = 4'(k) ^ (4'd1 << (k % 4));
            step($sformatf("stream_k%0d", k), 1'b1, 4'(k), sb, 1'b0, 1'b1, 1'b0, stream_exp(4'(k), sb));
            n_total++;
            assert ($onehot({g, e, s})) n_passed++;
            else $error("FAIL onehot_k%0d observed=%b expected=one-hot", k, {g, e, s});
        end
        last = stream_exp(4'd15, 4'd7);
        step("drop_valid", 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0, {1'b0, last[2:0]});
        step("drop_hold",  1'b0, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0, {1'b0, last[2:0]});

        // 5. Sign-sensitive vectors
`ifdef COMPARATOR_SIGNED_EN
        step("sign_8_7",  1'b1, 4'd8,  4'd7, 1'b0, 1'b1, 1'b0, V_S);
        step("sign_15_1", 1'b1, 4'd15, 4'd1, 1'b0, 1'b1, 1'b0, V_S);
`else
        step("sign_8_7",  1'b1, 4'd8,  4'd7, 1'b0, 1'b1, 1'b0, V_G);
        step("sign_15_1", 1'b1, 4'd15, 4'd1, 1'b0, 1'b1, 1'b0, V_G);
`endif

        // 6. Asynchronous reset between edges
        step("pre_rst", 1'b1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, V_E);
        drive(1'b1, 4'd9, 4'd3, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", ZERO);
        @(posedge clk);
        #1;
        check("rst_held", ZERO);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_idle", 1'b0, 4'd9, 4'd3, 1'b0, 1'b1, 1'b0, ZERO);
        step("post_rst_data", 1'b1, 4'd3, 4'd9, 1'b0, 1'b1, 1'b0, V_S);
        obs = {out_valid, g, e, s};

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
